// File: rtl/param_deserializer.sv
// Serial-to-parallel collector: gathers WIDTH bits (MSB- or LSB-first) into a word held until handshaken.
// Latency: one cycle from the completing bit to out_valid; a word completing while the slot is held unconsumed is dropped and flagged on overrun.
module param_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bit_valid,
    input  logic                           serial_in,
    input  logic                           frame_start,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overrun,
    output logic [$clog2(WIDTH+1)-1:0]     bit_count
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] first_bit;
    logic             complete;
    logic             slot_free;

    always_comb begin
        if (LSB_FIRST) begin
            shift_nxt = {serial_in, shift_reg[WIDTH-1:1]};
            first_bit = {serial_in, {(WIDTH-1){1'b0}}};
        end else begin
            shift_nxt = {shift_reg[WIDTH-2:0], serial_in};
            first_bit = {{(WIDTH-1){1'b0}}, serial_in};
        end
        // A resync bit always starts a new word, so it can never complete one.
        complete  = bit_valid && !frame_start && (bit_count == LAST_BIT);
        slot_free = !out_valid || out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_count <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (frame_start) begin
                shift_reg <= bit_valid ? first_bit : '0;
                bit_count <= bit_valid ? CNT_W'(1) : '0;
            end else if (bit_valid) begin
                shift_reg <= shift_nxt;
                bit_count <= complete ? '0 : bit_count + 1'b1;
            end

            if (complete) begin
                if (slot_free) begin
                    out_data  <= shift_nxt;
                    out_valid <= 1'b1;
                end else begin
                    overrun   <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_deserializer.sv
// Bench for param_deserializer: three instances (8 MSB-first, 8 LSB-first, 12 MSB-first) checked every cycle
// against a word-level model, plus directed streams with hand-computed expected words.
module tb_param_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] bv = '0;
    logic [2:0] si = '0;
    logic [2:0] fs = '0;
    logic [2:0] ordy = '0;
    logic [2:0] ov;
    logic [2:0] orun;
    logic [7:0]  od0, od1;
    logic [11:0] od2;
    logic [3:0]  bc0, bc1, bc2;
    logic [31:0] dout [3];
    logic [3:0]  bcnt [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb8 (
        .clk(clk), .rst_n(rst_n), .bit_valid(bv[0]), .serial_in(si[0]), .frame_start(fs[0]),
        .out_data(od0), .out_valid(ov[0]), .out_ready(ordy[0]), .overrun(orun[0]), .bit_count(bc0));
    param_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb8 (
        .clk(clk), .rst_n(rst_n), .bit_valid(bv[1]), .serial_in(si[1]), .frame_start(fs[1]),
        .out_data(od1), .out_valid(ov[1]), .out_ready(ordy[1]), .overrun(orun[1]), .bit_count(bc1));
    param_deserializer #(.WIDTH(12), .LSB_FIRST(1'b0)) u_msb12 (
        .clk(clk), .rst_n(rst_n), .bit_valid(bv[2]), .serial_in(si[2]), .frame_start(fs[2]),
        .out_data(od2), .out_valid(ov[2]), .out_ready(ordy[2]), .overrun(orun[2]), .bit_count(bc2));

    assign dout[0] = {24'd0, od0};
    assign dout[1] = {24'd0, od1};
    assign dout[2] = {20'd0, od2};
    assign bcnt[0] = bc0;
    assign bcnt[1] = bc1;
    assign bcnt[2] = bc2;

    // Word-level model: bit k of a stream lands at index k (LSB-first) or is shifted in from the right (MSB-first).
    int          mw [3] = '{8, 8, 12};
    bit          ml [3] = '{1'b0, 1'b1, 1'b0};
    int          m_cnt [3];
    logic [31:0] m_word [3];
    logic [31:0] m_data [3];
    bit          m_valid [3];
    bit          m_orun [3];
    bit          m_comp;
    logic [31:0] m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_word[i] = 0; m_data[i] = 0; m_valid[i] = 0; m_orun[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_comp    = 1'b0;
                m_done    = 0;
                m_orun[i] = 1'b0;
                if (fs[i]) begin
                    m_cnt[i]  = bv[i] ? 1 : 0;
                    m_word[i] = bv[i] ? {31'd0, si[i]} : 32'd0;
                end else if (bv[i]) begin
                    if (ml[i]) m_word[i] = m_word[i] | ({31'd0, si[i]} << m_cnt[i]);
                    else       m_word[i] = (m_word[i] << 1) | {31'd0, si[i]};
                    m_cnt[i]++;
                    if (m_cnt[i] == mw[i]) begin
                        m_comp    = 1'b1;
                        m_done    = m_word[i] & ((32'd1 << mw[i]) - 32'd1);
                        m_cnt[i]  = 0;
                        m_word[i] = 0;
                    end
                end
                if (m_comp) begin
                    if (!m_valid[i] || ordy[i]) begin
                        m_data[i]  = m_done;
                        m_valid[i] = 1'b1;
                    end else begin
                        m_orun[i] = 1'b1;
                    end
                end else if (m_valid[i] && ordy[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got=%0h want=%0h", nm, i, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("valid", i, {31'd0, ov[i]}, {31'd0, m_valid[i]});
            chk("overrun", i, {31'd0, orun[i]}, {31'd0, m_orun[i]});
            chk("bit_count", i, {28'd0, bcnt[i]}, m_cnt[i]);
            if (m_valid[i]) chk("data", i, dout[i], m_data[i]);
        end
    end

    // Inputs change 2 time units after a rising edge; bits are sent in the order they are written.
    task automatic send_bits(input int i, input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            bv[i] = 1'b1;
            si[i] = bits[k];
            @(posedge clk); #2;
        end
        bv[i] = 1'b0;
        si[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", i, {31'd0, ov[i]}, 32'd0);
            chk("rst_data", i, dout[i], 32'd0);
            chk("rst_count", i, {28'd0, bcnt[i]}, 32'd0);
            chk("rst_overrun", i, {31'd0, orun[i]}, 32'd0);
        end
        rst_n = 1'b1;
        idle(1);

        // MSB-first 1,0,1,0,0,1,0,1 -> 0xA5
        ordy[0] = 1'b1;
        send_bits(0, 32'b1010010, 7);
        chk("a5_count7", 0, {28'd0, bc0}, 32'd7);
        chk("a5_notyet", 0, {31'd0, ov[0]}, 32'd0);
        send_bits(0, 32'b1, 1);
        chk("a5_valid", 0, {31'd0, ov[0]}, 32'd1);
        chk("a5_data", 0, dout[0], 32'hA5);
        chk("a5_model", 0, m_data[0], 32'hA5);
        chk("a5_count0", 0, {28'd0, bc0}, 32'd0);
        idle(1);
        chk("a5_drained", 0, {31'd0, ov[0]}, 32'd0);

        // LSB-first: same stream -> 0xA5, then 1,1,0,0,0,0,0,0 -> 0x03
        ordy[1] = 1'b1;
        send_bits(1, 32'hA5, 8);
        chk("lsb_a5", 1, dout[1], 32'hA5);
        send_bits(1, 32'hC0, 8);
        chk("lsb_03", 1, dout[1], 32'h03);
        chk("lsb_model", 1, m_data[1], 32'h03);

        // 12-bit, consumer stalled: second word is dropped with a single overrun pulse
        ordy[2] = 1'b0;
        send_bits(2, 32'hABC, 12);
        chk("w12_valid", 2, {31'd0, ov[2]}, 32'd1);
        chk("w12_abc", 2, dout[2], 32'hABC);
        send_bits(2, 32'h123, 12);
        chk("w12_overrun", 2, {31'd0, orun[2]}, 32'd1);
        chk("w12_held", 2, dout[2], 32'hABC);
        idle(1);
        chk("w12_pulse_end", 2, {31'd0, orun[2]}, 32'd0);
        ordy[2] = 1'b1;
        idle(1);
        chk("w12_drained", 2, {31'd0, ov[2]}, 32'd0);

        // Partial word discarded by frame_start
        send_bits(0, 32'h1F, 5);
        chk("fs_count5", 0, {28'd0, bc0}, 32'd5);
        fs[0] = 1'b1;
        idle(1);
        fs[0] = 1'b0;
        chk("fs_count0", 0, {28'd0, bc0}, 32'd0);
        send_bits(0, 32'h3C, 8);
        chk("fs_3c", 0, dout[0], 32'h3C);
        chk("fs_no_overrun", 0, {31'd0, orun[0]}, 32'd0);
        idle(1);

        // Completion in the same cycle as a handshake keeps out_valid high with the new word
        ordy[0] = 1'b0;
        send_bits(0, 32'h11, 8);
        send_bits(0, 32'h2D, 7);
        ordy[0] = 1'b1;
        send_bits(0, 32'h0, 1);
        chk("hs_valid", 0, {31'd0, ov[0]}, 32'd1);
        chk("hs_5a", 0, dout[0], 32'h5A);
        chk("hs_no_overrun", 0, {31'd0, orun[0]}, 32'd0);
        idle(1);
        chk("hs_drained", 0, {31'd0, ov[0]}, 32'd0);

        // Asynchronous reset mid-word with a held word
        ordy[0] = 1'b0;
        send_bits(0, 32'h77, 8);
        send_bits(0, 32'hF, 4);
        chk("ar_count4", 0, {28'd0, bc0}, 32'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 0, {31'd0, ov[0]}, 32'd0);
        chk("ar_data", 0, dout[0], 32'd0);
        chk("ar_count", 0, {28'd0, bc0}, 32'd0);
        chk("ar_overrun", 0, {31'd0, orun[0]}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        send_bits(0, 32'hFF, 8);
        chk("ar_ff", 0, dout[0], 32'hFF);

        // frame_start with a bit at WIDTH-1 restarts instead of completing
        send_bits(0, 32'h0, 7);
        fs[0] = 1'b1;
        send_bits(0, 32'h1, 1);
        fs[0] = 1'b0;
        chk("fs_last_count", 0, {28'd0, bc0}, 32'd1);
        chk("fs_last_nodone", 0, {31'd0, ov[0]}, 32'd0);

        // Random traffic with one asynchronous reset in the middle
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                bv[i]   = ($urandom_range(0, 3) != 0);
                si[i]   = 1'($urandom);
                fs[i]   = ($urandom_range(0, 15) == 0);
                ordy[i] = ($urandom_range(0, 2) != 0);
            end
            if (c == 1500) begin
                #4;
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            @(posedge clk); #2;
        end
        bv = '0; fs = '0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_deserializer.md
PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, collected word width; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0; 0 means first received bit lands in out_data[WIDTH-1], 1 means it lands in out_data[0].
REQ-003 Derived width CNT_W = clog2(WIDTH+1), not overridable.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 bit_valid  input  1  serial_in is sampled this cycle when high.
REQ-007 serial_in  input  1  serial data bit.
REQ-008 frame_start  input  1  resynchronise; discard partial word.
REQ-009 out_data  output  WIDTH  completed word, held while out_valid=1.
REQ-010 out_valid  output  1  out_data holds an unconsumed word.
REQ-011 out_ready  input  1  consumer accepts word when out_valid=1 and out_ready=1.
REQ-012 overrun  output  1  one-cycle pulse; completed word dropped.
REQ-013 bit_count  output  CNT_W  bits collected in current partial word, 0..WIDTH-1.

Function
REQ-014 All outputs registered; no combinational path from any input to any output.
REQ-015 Shift, MSB mode: shift_reg <= {shift_reg[WIDTH-2:0], serial_in} on each accepted bit.
REQ-016 Shift, LSB mode: shift_reg <= {serial_in, shift_reg[WIDTH-1:1]} on each accepted bit.
REQ-017 Accepted bit: bit_valid=1; bit_count increments by 1 per accepted bit.
REQ-018 Completion: accepted bit while bit_count=WIDTH-1; bit_count returns to 0 the same edge.
REQ-019 Completed word: the post-shift value, including the completing bit; 1-cycle latency from last bit to out_valid.
REQ-020 Output slot free: out_valid=0, or out_valid=1 and out_ready=1 in the completion cycle.
REQ-021 Completion with free slot: out_data <= completed word; out_valid <= 1.
REQ-022 Completion with out_valid=1 and out_ready=0: word dropped; out_data unchanged; out_valid stays 1; overrun pulses 1 next cycle.
REQ-023 Handshake without completion: out_valid=1 and out_ready=1 clears out_valid next cycle; out_data unchanged.
REQ-024 out_data stays stable while out_valid=1 and out_ready=0.
REQ-025 frame_start=1, bit_valid=0: bit_count <= 0; shift_reg <= 0; output slot unaffected.
REQ-026 frame_start=1, bit_valid=1: the bit becomes the first bit of a new word; bit_count <= 1; shift_reg holds only that bit, rest zero.
REQ-027 frame_start never produces a completion, even when bit_count=WIDTH-1.
REQ-028 WIDTH-bit words complete back-to-back with no idle cycles when bit_valid is held high.
REQ-029 overrun is low in every cycle not covered by REQ-022.

Reset
REQ-030 rst_n low: shift_reg=0, bit_count=0, out_data=0, out_valid=0, overrun=0, immediately and independent of clk.
REQ-031 Reset mid-word discards the partial word; the first accepted bit after release is bit 0 of a new word.
REQ-032 Reset while out_valid=1 discards the held word without an overrun pulse.

Verification
REQ-033 WIDTH=8, LSB_FIRST=0, out_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> out_valid high one cycle after the 8th bit, out_data=0xA5, bit_count=0.
REQ-034 WIDTH=8, LSB_FIRST=1, same bit stream -> out_data=0xA5 reversed, i.e. 0xA5 (palindrome check); then bits 1,1,0,0,0,0,0,0 -> out_data=0x03.
REQ-035 WIDTH=12, out_ready=0, two words 0xABC then 0x123 sent back-to-back -> out_data stays 0xABC, overrun=1 for exactly one cycle after the second word; raise out_ready -> out_valid drops next cycle.
REQ-036 WIDTH=8, 5 bits sent, then frame_start=1 with bit_valid=0, then 8 bits forming 0x3C -> out_data=0x3C, no overrun.
REQ-037 WIDTH=8, out_valid=1 with out_ready=1 in the same cycle as the completion of 0x5A -> out_valid stays 1, out_data=0x5A, no overrun.
REQ-038 rst_n asserted after 4 bits with out_valid=1 -> all outputs 0 immediately; the next 8 bits 0xFF give out_data=0xFF.
